// File: rtl/instr_fetch.sv
// instr_fetch: program counter, single-outstanding imem requests, {word, pc} buffer and redirect flush.
// Optional macro IFETCH_PREFETCH_EN selects a two-entry buffer, so fetching can continue behind a decode stall.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        resetN,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemRdata,
  input  logic        imemValid,
  output logic [31:0] instruct,
  output logic [31:0] instrPc,
  output logic        instrValid,
  input  logic        instrReady,
  input  logic        redirect,
  input  logic [31:0] redirectPc
);
`ifdef IFETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [CW-1:0] count_reg, count_next, wr_idx;
  logic [31:0]   word_reg [DEPTH];
  logic [31:0]   word_next [DEPTH];
  logic [31:0]   pc_reg [DEPTH];
  logic [31:0]   pc_next [DEPTH];
  logic          push, pop, flush, req;

  // Outputs are forced to their reset values while resetN is low, even before the first edge.
  assign instrValid = resetN && (count_reg != '0);
  assign instruct   = instrValid ? word_reg[0] : 32'h0;
  assign instrPc    = instrValid ? pc_reg[0] : 32'h0;
  assign imemReq    = resetN && req;
  assign imemAddr   = resetN ? fetch_pc_reg : RESET_PC;

  assign pop    = instrValid && instrReady && !redirect;
  assign wr_idx = count_reg - CW'(pop);

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    req           = 1'b0;
    push          = 1'b0;
    flush         = 1'b0;
    if (redirect) begin
      flush         = 1'b1;
      fetch_pc_next = redirectPc;
    end
    case (state_reg)
      FETCH: begin
        if (!redirect && (count_reg < FULL)) begin
          req        = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imemValid) begin
          state_next = FETCH;
          if (!redirect) begin
            push          = 1'b1;
            fetch_pc_next = fetch_pc_reg + PC_STEP;
          end
        end else if (redirect) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (imemValid) begin
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // Head is always entry 0: a pop shifts entries down, a push lands just above the survivors.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      word_next[i] = word_reg[i];
      pc_next[i]   = pc_reg[i];
    end
    if (pop) begin
      for (int i = 0; i + 1 < DEPTH; i++) begin
        word_next[i] = word_reg[i + 1];
        pc_next[i]   = pc_reg[i + 1];
      end
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == CW'(i)) begin
          word_next[i] = imemRdata;
          pc_next[i]   = fetch_pc_reg;
        end
      end
    end
    count_next = flush ? '0 : (count_reg + CW'(push) - CW'(pop));
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_reg    <= FETCH;
      fetch_pc_reg <= RESET_PC;
      count_reg    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_reg[i] <= 32'h0;
        pc_reg[i]   <= 32'h0;
      end
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      count_reg    <= count_next;
      for (int i = 0; i < DEPTH; i++) begin
        word_reg[i] <= word_next[i];
        pc_reg[i]   <= pc_next[i];
      end
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 32-bit stack processor, directly upstream of `controlPath`. Holds the program counter, issues one-outstanding requests to instruction memory, buffers returned words with their PCs, and presents them to the decode/control stage under a valid/ready handshake. Branch, call and ret outcomes from downstream arrive as a single redirect that flushes the buffer and discards any in-flight fetch.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `PC_STEP`, 4, sequential PC increment in bytes.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetN`  in  1  synchronous, active-low reset.
- `imemReq`  out  1  one-cycle fetch request pulse.
- `imemAddr`  out  32  fetch address; valid while `imemReq`=1.
- `imemRdata`  in  32  returned instruction word.
- `imemValid`  in  1  `imemRdata` valid, ≥1 cycle after the request.
- `instruct`  out  32  head-of-buffer instruction to `controlPath`.
- `instrPc`  out  32  address of `instruct`; call uses `instrPc`+`PC_STEP`.
- `instrValid`  out  1  buffer non-empty.
- `instrReady`  in  1  downstream consumes head when `instrValid`=1.
- `redirect`  in  1  taken branch/call/ret; one-cycle pulse.
- `redirectPc`  in  32  new fetch PC.

## Operation
- Buffer: FIFO of {word, pc}, depth DEPTH (see Configuration); `count` 0..DEPTH. Head drives `instruct`/`instrPc`; `instrValid` = (`count`≠0). Pop on `instrValid`&`instrReady`.
- `fetchPc` register; `imemAddr` = `fetchPc`.
- FSM states: FETCH, WAIT, DROP. Reset state FETCH.
- FETCH: `imemReq` = (`count`<DEPTH) & !`redirect` (combinational). When asserted → WAIT.
- WAIT: on `imemValid`: push {`imemRdata`, `fetchPc`}, `fetchPc` += `PC_STEP` (mod 2^32), → FETCH.
- DROP: on `imemValid`: discard data, → FETCH. No request issued.
- Redirect (any state), highest priority: `fetchPc` ← `redirectPc`; buffer cleared (`count`←0); pop ignored.
  - In FETCH: no request that cycle; stay FETCH.
  - In WAIT without `imemValid`: → DROP.
  - In WAIT/DROP with `imemValid` same cycle: data discarded, → FETCH.
  - In DROP without `imemValid`: stay DROP (new `fetchPc` kept).
- Push and pop same cycle: both take effect; `count` unchanged.
- Never more than one outstanding request; `imemValid` outside WAIT/DROP is ignored.
- PC arithmetic is 32-bit unsigned, wraps 32'hFFFF_FFFC → 0 silently.

## Timing
- Reset (`resetN`=0 at edge): `fetchPc`=`RESET_PC`, `count`=0, state FETCH, buffer contents 0. While `resetN`=0: `imemReq`=0, `instrValid`=0, `instruct`=0, `instrPc`=0, `imemAddr`=`RESET_PC`.
- Reset mid-operation overrides everything; an in-flight response arriving afterwards is ignored (state FETCH).
- First cycle after reset release: `imemReq`=1, `imemAddr`=`RESET_PC`.
- Request in cycle t, `imemValid` in cycle t+L (L≥1): `instrValid`=1 in t+L+1; next request earliest t+L+1.
- Redirect at cycle t: `instrValid`=0 in t+1; new request at `redirectPc` in t+1 (if FSM returns to FETCH) or one cycle after the dropped response.

## Configuration
- `IFETCH_PREFETCH_EN` defined: DEPTH=2; fetching continues while one instruction waits for `instrReady`, hiding one memory latency behind a decode stall.
- Undefined: DEPTH=1; a new request is issued only when the buffer is empty. All other behaviour identical.

## Test plan
- Reset release, memory latency 1, `instrReady`=1: requests at 0x0, 0x4, 0x8; `instruct`/`instrPc` follow with `instrValid` 2 cycles after each request.
- `instrReady`=0 with `IFETCH_PREFETCH_EN`: exactly two words buffered (0x0, 0x4), `imemReq` then stays 0; raising `instrReady` drains in order. Without macro: one word, no further request.
- Redirect to 0x100 while in WAIT, response 3 cycles later: response discarded, next `imemAddr`=0x100, first delivered `instrPc`=0x100.
- Redirect to 0x200 coinciding with `imemValid` and a pop: buffer empty next cycle, request to 0x200 next cycle, stale word never appears.
- `resetN`=0 for one cycle while a request is outstanding: outputs reset, late `imemValid` ignored, fetch restarts at `RESET_PC`.
- Redirect to 32'hFFFF_FFFC: delivered PCs 0xFFFFFFFC then 0x00000000.
